fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage RISC-V pipeline. It owns the program counter, drives the byte address into the instruction memory, and captures the returned word into the IF/ID pipeline register together with its PC and PC+4. It honours decode-stage stalls and execute-stage redirects (taken branch or jump), which flush the fetched slot. The IF/ID register is consumed by decode.

## Interface
- `XLEN`, 32: datapath and address width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `NOP_INSTR`, 32'h0000_0013: word placed in IF/ID when the slot is invalid (`addi x0,x0,0`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `imem_addr`  out  XLEN  byte address to the instruction memory; equals `pc_q`.
- `imem_rdata`  in  32  combinational read data for `imem_addr`, same cycle.
- `stall_i`  in  1  decode hazard: hold the PC and IF/ID.
- `redirect_i`  in  1  execute resolved a taken branch or jump.
- `redirect_pc_i`  in  XLEN  redirect target.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  XLEN  PC of the IF/ID instruction.
- `if_id_pc4`  out  XLEN  `if_id_pc + 4`.
- `if_id_instr`  out  32  fetched word; `NOP_INSTR` when invalid.
- `misalign_o`  out  1  sticky flag: a redirect target had `[1:0] != 0`.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.

## Operation
- Next PC, in priority order:
  - `redirect_i` selects `{redirect_pc_i[XLEN-1:2], 2'b00}`.
  - Otherwise `stall_i` selects `pc_q`.
  - Otherwise the next PC is `pc_q + 4`, a modulo-2^XLEN add that wraps silently from 0xFFFF_FFFC to 0.
- IF/ID update, in priority order:
  - `redirect_i` has priority over `stall_i`. The IF/ID instruction is younger than the redirecting one, so on redirect IF/ID loads valid=0, instr=`NOP_INSTR`, pc=0, pc4=0.
  - Otherwise `stall_i` holds every IF/ID field unchanged.
  - Otherwise IF/ID loads valid=1, pc=`pc_q`, pc4=`pc_q+4`, instr=`imem_rdata`.
- `misalign_o` is set when `redirect_i` is high and `redirect_pc_i[1:0] != 0`. It is cleared only by reset. The fetch still proceeds at the aligned address.
- `fetch_count` increments by 1 on every cycle IF/ID loads valid=1. It wraps at 2^32.

## Timing
- Reset is synchronous: a rising edge with `rstn`=0 sets:
  - `pc_q`=`RESET_PC`
  - `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc`=0, `if_id_pc4`=0
  - `misalign_o`=0, `fetch_count`=0
- Reset mid-operation overrides stall and redirect in the same cycle.
- While `rstn`=0 the memory returns 0, and nothing is captured.
- First edge with `rstn`=1: IF/ID captures the word at `RESET_PC`, so `if_id_valid`=1 one cycle after reset release.
- Fetch latency: `imem_addr` changes on the edge; the word is in IF/ID at the next edge (1 cycle).
- Redirect asserted in cycle N:
  - Cycle N+1: `imem_addr`=target and `if_id_valid`=0.
  - Cycle N+2: the target instruction is valid. This is a 1-bubble penalty.
- Stall asserted for k cycles: PC and IF/ID are frozen for k cycles; no instruction is lost or duplicated.
- Stall and redirect in the same cycle behave exactly as a redirect.
- A back-to-back redirect in cycle N+1 overrides the first redirect; only the last target is fetched.
- All outputs are registered except `imem_addr`, which is `pc_q` directly.

## Structure
- Shared package `riscv_pkg` holds `XLEN`, `NOP_INSTR` and the `if_id_t` struct (valid, pc, pc4, instr). Decode reuses `if_id_t`.
- One natural sub-module, `pc_reg`: the PC register, next-PC mux and +4 adder. `fetch_stage` adds the IF/ID register, the flag and the counter.

## Test plan
- Reset then sequential run, with the memory model holding 0x406283B3 at 0, 0x006382B3 at 4 and 0x405381B3 at 8:
  - Hold `rstn`=0 for 3 cycles, then release.
  - Required: `imem_addr` reads 0, 4, 8, …
  - Required: IF/ID shows (pc 0, 0x406283B3), (4, 0x006382B3), (8, 0x405381B3) in consecutive cycles, and `fetch_count`=3.
- Stall: assert `stall_i` for 2 cycles while PC=8.
  - Required: `imem_addr` stays 8.
  - Required: IF/ID holds (4, 0x006382B3) for both cycles; the next capture is (8, 0x405381B3) with no skip.
  - Required: `fetch_count` does not advance.
- Redirect at PC=8 to 0x20: pulse `redirect_i` with `redirect_pc_i`=0x20.
  - Required next cycle: `if_id_valid`=0, `if_id_instr`=0x13, `imem_addr`=0x20.
  - Required the cycle after: IF/ID pc=0x20, pc4=0x24.
- Stall plus redirect in the same cycle to 0x40.
  - Required: behaves as a plain redirect; `imem_addr`=0x40 next cycle and IF/ID is flushed.
- Misaligned redirect to 0x42.
  - Required: `imem_addr`=0x40 and `misalign_o`=1, sticky across 10 further cycles; a reset clears it.
- Reset mid-run: drive `rstn`=0 during a redirect.
  - Required next cycle: `pc_q`=`RESET_PC`, `if_id_valid`=0 and `fetch_count`=0; the redirect target is never fetched.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: datapath width, canonical NOP and the
// IF/ID register layout that decode also consumes.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [31:0]     instr;
   } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with redirect/stall/sequential next-PC selection and the
// +4 incrementer shared with the IF/ID register.
module pc_reg
   import riscv_pkg::*;
#(
   parameter int unsigned          XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]      RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4
);

   logic [XLEN-1:0] pc_next;

   // Modulo add: wraps from the top word back to 0 without any flag.
   assign pc4 = pc + XLEN'(4);

   always_comb begin
      pc_next = pc4;
      if (redirect) begin
         pc_next = {redirect_pc[XLEN-1:2], 2'b00};
      end else if (stall) begin
         pc_next = pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the instruction memory from the PC and
// captures the returned word into the IF/ID register for decode.
module fetch_stage
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rstn,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc4,
   output logic [31:0]     if_id_instr,
   output logic            misalign_o,
   output logic [31:0]     fetch_count
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4;
   if_id_t          if_id_q;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall_i),
      .redirect    (redirect_i),
      .redirect_pc (redirect_pc_i),
      .pc          (pc_q),
      .pc4         (pc_plus4)
   );

   assign imem_addr = pc_q;

   // Redirect flushes the slot even under stall: the fetched word is younger
   // than the redirecting instruction and must never reach decode.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         if_id_q.valid <= 1'b0;
         if_id_q.pc    <= '0;
         if_id_q.pc4   <= '0;
         if_id_q.instr <= NOP_INSTR;
         misalign_o    <= 1'b0;
         fetch_count   <= '0;
      end else if (redirect_i) begin
         if_id_q.valid <= 1'b0;
         if_id_q.pc    <= '0;
         if_id_q.pc4   <= '0;
         if_id_q.instr <= NOP_INSTR;
         if (redirect_pc_i[1:0] != 2'b00) begin
            misalign_o <= 1'b1;
         end
      end else if (!stall_i) begin
         if_id_q.valid <= 1'b1;
         if_id_q.pc    <= pc_q;
         if_id_q.pc4   <= pc_plus4;
         if_id_q.instr <= imem_rdata;
         fetch_count   <= fetch_count + 32'd1;
      end
   end

   assign if_id_valid = if_id_q.valid;
   assign if_id_pc    = if_id_q.pc;
   assign if_id_pc4   = if_id_q.pc4;
   assign if_id_instr = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a step-level
// reference model of PC, IF/ID, misalign flag and fetch counter.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc4;
   logic [31:0] if_id_instr;
   logic        misalign_o;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [31:0] m_pc, m_ipc, m_pc4, m_instr, m_cnt;
   logic        m_v, m_mis;

   always #5 clk = ~clk;

   fetch_stage #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .if_id_valid   (if_id_valid),
      .if_id_pc      (if_id_pc),
      .if_id_pc4     (if_id_pc4),
      .if_id_instr   (if_id_instr),
      .misalign_o    (misalign_o),
      .fetch_count   (fetch_count)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   mem_word = 32'h406283B3;
         32'h4:   mem_word = 32'h006382B3;
         32'h8:   mem_word = 32'h405381B3;
         default: mem_word = (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
      endcase
   endfunction

   assign imem_rdata = rstn ? mem_word(imem_addr) : 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("imem_addr",   imem_addr,          m_pc);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_v});
      check("if_id_pc",    if_id_pc,           m_ipc);
      check("if_id_pc4",   if_id_pc4,          m_pc4);
      check("if_id_instr", if_id_instr,        m_instr);
      check("misalign_o",  {31'b0, misalign_o}, {31'b0, m_mis});
      check("fetch_count", fetch_count,        m_cnt);
   endtask

   // One clock edge with the given controls, then advance the model and compare.
   task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
      rstn = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
      @(posedge clk);
      if (!r) begin
         m_pc = 32'h0; m_v = 0; m_ipc = 0; m_pc4 = 0; m_instr = 32'h13;
         m_mis = 0; m_cnt = 0;
      end else if (rd) begin
         m_v = 0; m_ipc = 0; m_pc4 = 0; m_instr = 32'h13;
         if (rpc % 4 != 0) m_mis = 1;
         m_pc = rpc - (rpc % 4);
      end else if (!st) begin
         m_v = 1; m_ipc = m_pc; m_pc4 = m_pc + 4; m_instr = mem_word(m_pc);
         m_cnt = m_cnt + 1;
         m_pc = m_pc + 4;
      end
      #1;
      check_all();
   endtask

   initial begin
      rstn = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;

      // reset held 3 cycles, then sequential run
      repeat (3) step(0, 0, 0, 0);
      check("rst_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, 32'h13);
      step(1, 0, 0, 0);
      check("seq0_pc", if_id_pc, 32'h0);
      check("seq0_instr", if_id_instr, 32'h406283B3);
      step(1, 0, 0, 0);
      check("seq1_instr", if_id_instr, 32'h006382B3);
      step(1, 0, 0, 0);
      check("seq2_instr", if_id_instr, 32'h405381B3);
      check("seq_count", fetch_count, 32'd3);

      // stall at PC=8 for two cycles
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_pc", if_id_pc, 32'h4);
      step(1, 1, 0, 0);
      check("stall_instr", if_id_instr, 32'h006382B3);
      check("stall_count", fetch_count, 32'd2);
      step(1, 0, 0, 0);
      check("unstall_pc", if_id_pc, 32'h8);
      check("unstall_instr", if_id_instr, 32'h405381B3);

      // redirect to 0x20
      step(1, 0, 1, 32'h20);
      check("redir_addr", imem_addr, 32'h20);
      check("redir_instr", if_id_instr, 32'h13);
      step(1, 0, 0, 0);
      check("redir_pc", if_id_pc, 32'h20);
      check("redir_pc4", if_id_pc4, 32'h24);

      // stall plus redirect behaves as redirect
      step(1, 1, 1, 32'h40);
      check("sr_addr", imem_addr, 32'h40);
      check("sr_valid", {31'b0, if_id_valid}, 32'd0);
      step(1, 0, 0, 0);

      // back-to-back redirects: only the last target is fetched
      step(1, 0, 1, 32'h100);
      step(1, 0, 1, 32'h200);
      step(1, 0, 0, 0);
      check("b2b_pc", if_id_pc, 32'h200);

      // PC wrap at the top of the address space
      step(1, 0, 1, 32'hFFFF_FFFC);
      step(1, 0, 0, 0);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc4", if_id_pc4, 32'h0);

      // misaligned redirect, sticky until reset
      step(1, 0, 1, 32'h42);
      check("mis_addr", imem_addr, 32'h40);
      repeat (10) step(1, 0, 0, 0);
      check("mis_sticky", {31'b0, misalign_o}, 32'd1);
      step(0, 0, 0, 0);
      check("mis_clear", {31'b0, misalign_o}, 32'd0);

      // reset during a redirect
      repeat (3) step(1, 0, 0, 0);
      step(0, 1, 1, 32'h80);
      check("rr_addr", imem_addr, 32'h0);
      check("rr_count", fetch_count, 32'd0);
      step(1, 0, 0, 0);
      check("rr_pc", if_id_pc, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         step($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0, tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
